// File: rtl/pkg_ascensor.sv
// rtl/pkg_ascensor.sv - shared floor-code constants, FSM encoding and pointer wrap helper
package pkg_ascensor;

    // Default floor-code width and number of served floors (codes 0..NUM_PISOS_DEF-1)
    localparam int PISO_W_DEF    = 4;
    localparam int NUM_PISOS_DEF = 11;

    // Request-queue controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSCA   = 2'd1,
        INSERTA = 2'd2,
        RESP    = 2'd3
    } estado_t;

    // Circular pointer increment; depth need not be a power of two
    function automatic int unsigned sig_ptr(input int unsigned ptr, input int unsigned prof);
        return (ptr == prof - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cola_pisos_mem.sv
// rtl/cola_pisos_mem.sv - PROF x PISO_W register array, one sync write, two async reads
//
// Ports:
//   clk               rising-edge clock
//   we/waddr/wdata    synchronous write port (tail insertion)
//   raddr_a/rdata_a   combinational read (queue head)
//   raddr_b/rdata_b   combinational read (search index)
// Contents are intentionally not reset.
module cola_mem #(
    parameter int PROF   = 11,
    parameter int PISO_W = 4,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [PISO_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [PISO_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [PISO_W-1:0] rdata_b
);

    logic [PISO_W-1:0] mem [PROF];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/cola_pisos.sv
// rtl/cola_pisos.sv - deduplicating circular FIFO of elevator floor requests
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   boton/boton_valid/boton_ready    request push port
//   hecho                            one-cycle pulse when a request has been resolved
//   encontrado/invalido/desborde     outcome flags, held until the next accepted push
//   sal_piso/sal_valid/sal_ready     head-of-queue pop port
//   ocupadas/vacia/llena             occupancy status
module cola_pisos
    import pkg_ascensor::*;
#(
    parameter int PISO_W    = PISO_W_DEF,
    parameter int NUM_PISOS = NUM_PISOS_DEF,
    parameter int PROF      = 11,
    localparam int CNT_W    = $clog2(PROF + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PISO_W-1:0] boton,
    input  logic              boton_valid,
    output logic              boton_ready,
    output logic              hecho,
    output logic              encontrado,
    output logic              invalido,
    output logic              desborde,
    output logic [PISO_W-1:0] sal_piso,
    output logic              sal_valid,
    input  logic              sal_ready,
    output logic [CNT_W-1:0]  ocupadas,
    output logic              vacia,
    output logic              llena
);

    localparam int PTR_W = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [PISO_W:0] LIM_PISO = NUM_PISOS[PISO_W:0];

    estado_t            estado, estado_n;
    logic [PTR_W-1:0]   head, head_n;
    logic [CNT_W-1:0]   ocup_n, ocup_post;
    logic [CNT_W-1:0]   idx, idx_n;
    logic [PISO_W-1:0]  piso_r, piso_n;
    logic               enc_n, inv_n, des_n;
    logic               pop, push, we;
    logic [PTR_W-1:0]   waddr, baddr;
    logic [PISO_W-1:0]  rd_busca;

    // (a + b) mod PROF for a < PROF, b <= PROF, via compare-and-subtract
    function automatic logic [PTR_W-1:0] mod_add(input logic [PTR_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s >= SUM_W'(PROF)) begin
            s = s - SUM_W'(PROF);
        end
        return s[PTR_W-1:0];
    endfunction

    assign waddr = mod_add(head, ocupadas);
    assign baddr = mod_add(head, idx);

    cola_mem #(
        .PROF   (PROF),
        .PISO_W (PISO_W),
        .AW     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (piso_r),
        .raddr_a (head),
        .rdata_a (sal_piso),
        .raddr_b (baddr),
        .rdata_b (rd_busca)
    );

    assign vacia       = (ocupadas == '0);
    assign llena       = (ocupadas == CNT_W'(PROF));
    assign boton_ready = (estado == IDLE);
    assign sal_valid   = (estado == IDLE) && !vacia;
    assign hecho       = (estado == RESP);
    assign pop         = sal_valid && sal_ready;
    assign push        = boton_valid && boton_ready;

    // Pop is committed before the push is evaluated, so the search sees post-pop contents
    assign ocup_post = pop ? (ocupadas - CNT_W'(1)) : ocupadas;

    always_comb begin
        estado_n = estado;
        head_n   = head;
        ocup_n   = ocupadas;
        idx_n    = idx;
        piso_n   = piso_r;
        enc_n    = encontrado;
        inv_n    = invalido;
        des_n    = desborde;
        we       = 1'b0;
        case (estado)
            IDLE: begin
                if (pop) begin
                    head_n = PTR_W'(sig_ptr(32'(head), PROF));
                    ocup_n = ocup_post;
                end
                if (push) begin
                    piso_n = boton;
                    enc_n  = 1'b0;
                    inv_n  = 1'b0;
                    des_n  = 1'b0;
                    idx_n  = '0;
                    if ({1'b0, boton} >= LIM_PISO) begin
                        inv_n    = 1'b1;
                        estado_n = RESP;
                    end else if (ocup_post == '0) begin
                        estado_n = INSERTA;
                    end else begin
                        estado_n = BUSCA;
                    end
                end
            end
            BUSCA: begin
                if (rd_busca == piso_r) begin
                    enc_n    = 1'b1;
                    estado_n = RESP;
                end else if (idx == ocupadas - CNT_W'(1)) begin
                    estado_n = INSERTA;
                end else begin
                    idx_n = idx + CNT_W'(1);
                end
            end
            INSERTA: begin
                if (llena) begin
                    des_n = 1'b1;
                end else begin
                    we     = 1'b1;
                    ocup_n = ocupadas + CNT_W'(1);
                end
                estado_n = RESP;
            end
            RESP: begin
                estado_n = IDLE;
            end
            default: begin
                estado_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= IDLE;
            head       <= '0;
            ocupadas   <= '0;
            idx        <= '0;
            encontrado <= 1'b0;
            invalido   <= 1'b0;
            desborde   <= 1'b0;
        end else begin
            estado     <= estado_n;
            head       <= head_n;
            ocupadas   <= ocup_n;
            idx        <= idx_n;
            encontrado <= enc_n;
            invalido   <= inv_n;
            desborde   <= des_n;
        end
    end

    always_ff @(posedge clk) begin
        piso_r <= piso_n;
    end

endmodule

// File: tb/tb_cola_pisos.sv
// tb/tb_cola_pisos.sv - scoreboard testbench for cola_pisos
module tb_cola_pisos;

    localparam int PISO_W = 4;
    localparam int PROF   = 11;
    localparam int CNT_W  = $clog2(PROF + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PISO_W-1:0] boton = '0;
    logic              boton_valid = 1'b0;
    logic              boton_ready;
    logic              hecho, encontrado, invalido, desborde;
    logic [PISO_W-1:0] sal_piso;
    logic              sal_valid;
    logic              sal_ready = 1'b0;
    logic [CNT_W-1:0]  ocupadas;
    logic              vacia, llena;

    cola_pisos #(.PISO_W(PISO_W), .NUM_PISOS(11), .PROF(PROF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .boton       (boton),
        .boton_valid (boton_valid),
        .boton_ready (boton_ready),
        .hecho       (hecho),
        .encontrado  (encontrado),
        .invalido    (invalido),
        .desborde    (desborde),
        .sal_piso    (sal_piso),
        .sal_valid   (sal_valid),
        .sal_ready   (sal_ready),
        .ocupadas    (ocupadas),
        .vacia       (vacia),
        .llena       (llena)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic enc;
        logic inv;
        logic des;
        int   lat;
        int   oc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every hecho pulse consumes one expected outcome
    initial forever begin
        exp_t x;
        @(negedge clk);
        if (rst_n && hecho) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL hecho_unexpected: got hecho=1 expected no pending request");
            end else begin
                x = sb.pop_front();
                chk("encontrado", int'(encontrado), int'(x.enc));
                chk("invalido", int'(invalido), int'(x.inv));
                chk("desborde", int'(desborde), int'(x.des));
                chk("latency", cyc - accept_cyc + 1, x.lat);
                chk("ocupadas_at_hecho", int'(ocupadas), x.oc);
            end
            done_cnt++;
        end
    end

    task automatic push(input int f, input logic e, input logic i, input logic d,
                        input int lat, input int oc, input logic sr);
        exp_t x;
        int   t;
        int   start_done;
        @(negedge clk);
        t = 0;
        while (!boton_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!boton_ready) chk("boton_ready_timeout", 0, 1);
        x.enc = e; x.inv = i; x.des = d; x.lat = lat; x.oc = oc;
        sb.push_back(x);
        start_done  = done_cnt;
        boton       = f[PISO_W-1:0];
        boton_valid = 1'b1;
        sal_ready   = sr;
        @(posedge clk);
        #1;
        accept_cyc  = cyc;
        boton_valid = 1'b0;
        sal_ready   = 1'b0;
        t = 0;
        while (done_cnt == start_done && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (done_cnt == start_done) chk("hecho_timeout", 0, 1);
    endtask

    task automatic pop1();
        @(negedge clk);
        sal_ready = 1'b1;
        @(posedge clk);
        #1;
        sal_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [PISO_W-1:0] m[$];
    logic [PISO_W-1:0] front;

    initial begin
        do_reset();
        chk("reset_ocupadas", int'(ocupadas), 0);
        chk("reset_vacia", int'(vacia), 1);
        chk("reset_llena", int'(llena), 0);
        chk("reset_boton_ready", int'(boton_ready), 1);
        chk("reset_sal_valid", int'(sal_valid), 0);
        chk("reset_hecho", int'(hecho), 0);
        chk("reset_flags", int'({encontrado, invalido, desborde}), 0);

        // Basic insertion and duplicate/invalid detection
        push(3, 0, 0, 0, 2, 1, 0);
        push(7, 0, 0, 0, 3, 2, 0);
        push(5, 0, 0, 0, 4, 3, 0);
        @(negedge clk);
        chk("sal_piso_head3", int'(sal_piso), 3);
        chk("sal_valid_3", int'(sal_valid), 1);
        push(7, 1, 0, 0, 3, 3, 0);
        push(12, 0, 1, 0, 1, 3, 0);
        repeat (3) @(negedge clk);
        chk("invalido_held", int'(invalido), 1);
        chk("ocupadas_after_invalid", int'(ocupadas), 3);
        chk("sal_piso_after_invalid", int'(sal_piso), 3);

        // Fill the queue completely
        do_reset();
        for (int i = 0; i < 11; i++) push(i, 0, 0, 0, i + 2, i + 1, 0);
        @(negedge clk);
        chk("llena_full", int'(llena), 1);
        chk("ocupadas_full", int'(ocupadas), 11);
        push(4, 1, 0, 0, 6, 11, 0);
        @(negedge clk);
        chk("sal_piso_before_pop", int'(sal_piso), 0);
        pop1();
        @(negedge clk);
        chk("ocupadas_after_pop", int'(ocupadas), 10);
        chk("sal_piso_after_pop", int'(sal_piso), 1);
        push(10, 1, 0, 0, 11, 10, 0);
        push(0, 0, 0, 0, 12, 11, 0);
        @(negedge clk);
        chk("llena_refill", int'(llena), 1);
        push(3, 1, 0, 0, 4, 11, 0);

        // Simultaneous pop and push, repeated until head and tail wrap
        do_reset();
        push(3, 0, 0, 0, 2, 1, 0);
        push(7, 0, 0, 0, 3, 2, 0);
        m.push_back(4'd3);
        m.push_back(4'd7);
        for (int k = 0; k < 12; k++) begin
            front = m.pop_front();
            @(negedge clk);
            chk("popped_head", int'(sal_piso), int'(front));
            push(int'(front), 0, 0, 0, 3, 2, 1);
            m.push_back(front);
        end
        @(negedge clk);
        chk("final_head", int'(sal_piso), int'(m[0]));
        chk("final_ocupadas", int'(ocupadas), 2);

        // Reset in the middle of a search
        do_reset();
        for (int i = 0; i < 5; i++) push(i, 0, 0, 0, i + 2, i + 1, 0);
        @(negedge clk);
        boton       = 4'd9;
        boton_valid = 1'b1;
        @(posedge clk);
        #1;
        boton_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_busca_not_ready", int'(boton_ready), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_ocupadas", int'(ocupadas), 0);
        chk("midreset_vacia", int'(vacia), 1);
        chk("midreset_hecho", int'(hecho), 0);
        chk("midreset_boton_ready", int'(boton_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
